booth16_mul_ctrl: RTL

//  Sequencing FSM for the radix-16 Booth multiplier datapath.
//  - Accepts operand requests over a valid/ready handshake.
//  - Drives the load/accumulate controls of the 4-bit-per-cycle multiplier shift register, multiplicand register and accumulator.
//  - Holds the finished product for the consumer over a second valid/ready handshake.
//  - Sits between the requester and the datapath; it never touches operand or product data.

---
 rtl/booth16_mul_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/booth16_mul_ctrl.sv
// booth16_mul_ctrl
//   Sequencing FSM for a radix-16 Booth multiplier datapath. Accepts an
//   operand request, then steps the datapath through ITERS Booth digits,
//   one per cycle. After that it holds the finished product for the
//   consumer until the consumer takes it. Operand and product data never
//   pass through this block.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a request; load/acc_clr follow in_valid_i
//   RUN   | accumulating Booth digit cnt_q (0..ITERS-1), acc_en high
//   DONE  | product final, out_valid_o held until out_ready_i
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   in_valid_i     requester presents operands
//   in_ready_o     controller can accept a request (IDLE)
//   out_valid_o    accumulator holds the final product (DONE)
//   out_ready_i    consumer takes the product
//   load_o         load multiplier shift reg + multiplicand reg, clear last_bit
//   acc_clr_o      synchronous accumulator clear
//   acc_en_o       add current Booth partial product into accumulator
//   digit_idx_o    Booth digit being consumed (weight 16^idx), 0 outside RUN
//   last_digit_o   this acc_en cycle consumes digit ITERS-1
//   busy_o         state is not IDLE

module booth16_mul_ctrl #(
   parameter  int WIDTH = 32,
   localparam int ITERS = WIDTH / 4,
   localparam int CW    = $clog2(ITERS)
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic          load_o,
   output logic          acc_clr_o,
   output logic          acc_en_o,
   output logic [CW-1:0] digit_idx_o,
   output logic          last_digit_o,
   output logic          busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      in_ready_o   = 1'b0;
      out_valid_o  = 1'b0;
      load_o       = 1'b0;
      acc_clr_o    = 1'b0;
      acc_en_o     = 1'b0;
      digit_idx_o  = '0;
      last_digit_o = 1'b0;
      busy_o       = 1'b1;

      unique case (state_q)
         IDLE: begin
            in_ready_o = 1'b1;
            busy_o     = 1'b0;
            // Mealy so the datapath captures operands on the accept edge;
            // gated by reset so nothing is loaded while reset is held.
            load_o     = in_valid_i & rst_n_i;
            acc_clr_o  = in_valid_i & rst_n_i;
            cnt_d      = '0;
            if (in_valid_i) begin
               state_d = RUN;
            end
         end

         RUN: begin
            acc_en_o     = 1'b1;
            digit_idx_o  = cnt_q;
            last_digit_o = (cnt_q == LAST_CNT);
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DONE: begin
            out_valid_o = 1'b1;
            // Exit always passes through IDLE, so no accept in this cycle.
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule
